// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map,
// buffer depth and small encoding helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        RELEASE
    } kp_state_t;

    localparam int KP_FIFO_DEPTH = 4;

    // Indexed {row, col}; element 0 is row 0 / col 0 (key '1').
    localparam logic [15:0][3:0] KEY_MAP = '{
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [1:0] lowest_row(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key hand-off between the scanner (master) and the consuming core (slave).
interface keypad_scanner_if;

    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_irq;
    logic       key_ovf;

    modport master (
        output key_code,
        output key_valid,
        output key_irq,
        output key_ovf,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_irq,
        input  key_ovf,
        output key_ack
    );

endinterface

// File: rtl/keypad_fifo.sv
// Key buffer. KEYPAD_FIFO_EN selects a 4-entry circular FIFO; otherwise a
// single holding register. head/empty/full are registered.
module keypad_fifo
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [3:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [3:0] head
);

`ifdef KEYPAD_FIFO_EN
    localparam int PTR_W = $clog2(KP_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0]       mem [KP_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             pop_ok;
    logic             push_ok;
    logic [3:0]       head_n;

    // A pop frees a slot in the same cycle, so a full buffer still accepts a push.
    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        rd_ptr_n = rd_ptr + PTR_W'(pop_ok);
        count_n  = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        head_n   = head;
        if (push_ok && (wr_ptr == rd_ptr_n)) begin
            head_n = push_data;
        end else if (count_n != '0) begin
            head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            head   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            empty  <= (count_n == '0);
            full   <= (count_n == CNT_W'(KP_FIFO_DEPTH));
            head   <= head_n;
        end
    end
`else
    logic pop_ok;

    always_comb begin
        pop_ok = pop & ~empty;
        full   = ~empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            empty <= 1'b1;
            head  <= '0;
        end else if (push && (empty || pop_ok)) begin
            empty <= 1'b0;
            head  <= push_data;
        end else if (pop_ok) begin
            empty <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a valid/ack key buffer.
// Buffer type is selected by the KEYPAD_FIFO_EN macro (see keypad_fifo).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        Keypad_rows,
    output logic [3:0]        Keypad_cols,
    keypad_scanner_if.master  kbus
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);

    kp_state_t        state;
    logic [3:0]       rows_m;
    logic [3:0]       rows_s;
    logic [3:0]       pat;
    logic [1:0]       col;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             push;
    logic             pop;
    logic [3:0]       push_code;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       head;

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_m <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            rows_m <= Keypad_rows;
            rows_s <= rows_m;
        end
    end

    always_comb begin
        pop       = ~fifo_empty & kbus.key_ack;
        push      = (state == EMIT) & ~(fifo_full & ~pop);
        push_code = KEY_MAP[{lowest_row(pat), col}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            cnt         <= '0;
            col         <= 2'd0;
            Keypad_cols <= col_drive(2'd0);
            ovf         <= 1'b0;
        end else begin
            unique case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (rows_s == 4'hF) begin
                            col         <= col + 2'd1;
                            Keypad_cols <= col_drive(col + 2'd1);
                        end else begin
                            pat   <= rows_s;
                            state <= DEBOUNCE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (rows_s != pat) begin
                        state       <= SCAN;
                        cnt         <= '0;
                        col         <= col + 2'd1;
                        Keypad_cols <= col_drive(col + 2'd1);
                    end else if (cnt == DEB_LAST) begin
                        state <= EMIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EMIT: begin
                    if (fifo_full && !pop) ovf <= 1'b1;
                    state <= RELEASE;
                    cnt   <= '0;
                end
                RELEASE: begin
                    // Any row still low restarts the release count.
                    if (rows_s != 4'hF) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= SCAN;
                        cnt         <= '0;
                        col         <= col + 2'd1;
                        Keypad_cols <= col_drive(col + 2'd1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    keypad_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign kbus.key_code  = head;
    assign kbus.key_valid = ~fifo_empty;
    assign kbus.key_irq   = ~fifo_empty;
    assign kbus.key_ovf   = ovf;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 matrix keypad on the board and turns key presses into debounced 4-bit key codes for the minimal system core. It sits directly upstream of `minsys`: it drives `Keypad_cols`, samples `Keypad_rows`, and presents each key through a valid/ack handshake. It also raises the level interrupt that feeds the core's `EI` input.

## Interface

Parameters:
- `SCAN_DIV`, default 1000: clock cycles each column is driven. Minimum 4.
- `DEBOUNCE_CNT`, default 20000: consecutive matching samples required for press and for release. Minimum 2.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `Keypad_rows`, in, 4: row sense lines. Active-low, pulled up; `4'b1111` means no key.
- `Keypad_cols`, out, 4: column drive. Exactly one bit is low at a time.
- `key_code`, out, 4: code of the key at the head of the buffer.
- `key_valid`, out, 1: buffer is non-empty.
- `key_ack`, in, 1: consumer pops the head entry when `key_valid & key_ack`.
- `key_irq`, out, 1: interrupt request, equal to `key_valid`; wired to `EI`.
- `key_ovf`, out, 1: sticky flag, set when a debounced key is dropped because the buffer is full.

## Operation

- **Row synchronizer:** 2-flop synchronizer on `Keypad_rows`. All row logic uses the synchronized value `rows_s`.
- **Column drive:** `Keypad_cols = ~(4'b0001 << col)`. Column index `col` runs 0..3 and wraps 3→0.
- **FSM states:** SCAN, DEBOUNCE, EMIT, RELEASE.
- **SCAN:**
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle, `rows_s` is sampled.
  - If `rows_s == 4'hF`, advance `col` and restart the dwell.
  - Otherwise latch the pattern and `col`, and go to DEBOUNCE. The column stays driven.
- **DEBOUNCE:**
  - Counter starts at 0 on entry and increments each cycle that `rows_s` equals the latched pattern.
  - Any mismatch returns to SCAN; `col` advances and the dwell restarts.
  - When the counter reaches DEBOUNCE_CNT-1 on a match, go to EMIT.
- **EMIT (1 cycle):**
  - Encode the key from the lowest-index low row and the latched `col`.
  - Push the code into the buffer, or set `key_ovf` if the buffer is full.
  - Go to RELEASE.
- **RELEASE:**
  - Counter counts consecutive cycles of `rows_s == 4'hF`. Any low row resets it to 0.
  - At DEBOUNCE_CNT-1, go to SCAN with `col` advanced.
  - Holding a key produces exactly one code.
- **Key map (row r, col c):**
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- **Multiple low rows:** the lowest row index wins.
- **Handshake:** `key_code` is stable while `key_valid=1` and no ack occurs. A push and a pop in the same cycle are both honoured, including when the buffer is full: the pop frees a slot, so there is no overflow.
- **Reset values:**
  - `Keypad_cols=4'b1110`, `key_valid=0`, `key_irq=0`, `key_ovf=0`, `key_code=0`.
  - FSM in SCAN, counters 0, buffer empty.
- **Reset mid-operation:** any state returns to SCAN next cycle. Buffered keys are discarded.

## Timing

- All outputs are registered.
- Press latency, from the edge on which `rows_s` first shows the press in the active column's sample cycle:
  - DEBOUNCE entered next cycle.
  - EMIT DEBOUNCE_CNT cycles later.
  - `key_valid` high the cycle after EMIT.
- Pop: `key_valid`/`key_code` update the cycle after `key_valid & key_ack`.
- `key_ack` while `key_valid=0` is ignored.

## Configuration

- `KEYPAD_FIFO_EN` defined: the buffer is a 4-entry circular FIFO. `key_code` shows the oldest entry, and `key_ovf` sets only on a push into 4 held entries.
- `KEYPAD_FIFO_EN` undefined: the buffer is a single holding register.
  - A push while full and not popped is dropped and sets `key_ovf`.
  - A push together with a pop loads the new code and keeps `key_valid` high.

## Structure

- Package `keypad_pkg` holds:
  - the FSM state enum `kp_state_t`;
  - the `KEY_MAP` constant (16×4-bit, indexed `{row,col}`);
  - the FIFO depth constant `KP_FIFO_DEPTH=4`.
- One sub-module, `keypad_fifo`: the buffer. Its internals are selected by `KEYPAD_FIFO_EN`, and it exposes push/pop/full/empty/head.

## Test plan

Bench uses SCAN_DIV=4 and DEBOUNCE_CNT=8.

1. Hold rows at `4'b1111` for 100 cycles → `Keypad_cols` cycles 1110, 1101, 1011, 0111, changing every 4 cycles; `key_valid` stays 0.
2. Pull row1 low only while col2 is driven, hold 40 cycles, then release → one entry with `key_code=4'h6`, `key_irq=1`; ack → `key_valid=0` next cycle.
3. Bounce row0/col0 low for 3 cycles, high 1, low 3 → no code emitted and the scan resumes; then hold steady → `key_code=4'h1`.
4. Hold row3/col1 and row2/col1 together → `key_code=4'h8` (row2 wins); holding for 200 cycles yields exactly one entry.
5. With FIFO: press 5 keys, no ack → 4 entries in press order and `key_ovf=1`. Without FIFO: press 2 keys → first kept, `key_ovf=1`.
6. Assert `rst` during DEBOUNCE with one key buffered → next cycle `key_valid=0`, `key_ovf=0`, `Keypad_cols=4'b1110`.
